adder4_accum: RTL and testbench

Registered accumulate stage directly downstream of the 4-bit ripple adder `adder4`. It consumes each `{c_out, sum}` result as a 5-bit unsigned value over a valid/ready handshake and sums COUNT consecutive results into a wider accumulator. It then presents the block total with a sticky overflow flag and holds it until the consumer accepts it. It converts the adder's per-operation combinational output into block-level running totals for the next stage.

---
 rtl/adder4_accum.sv | 119 +++++++++++
 tb/tb_adder4_accum.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/adder4_accum.sv
// Accumulates COUNT consecutive {c_out, sum} results from adder4 into a block total with a sticky overflow flag.
// Optional build macro: ADDER4_ACCUM_SATURATE_EN (saturate the accumulator on overflow instead of wrapping).
module adder4_accum #(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 8,
  parameter int COUNT     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_sum,
  input  logic                 in_cout,
  input  logic                 clear,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_acc,
  output logic                 out_ovf
);

  localparam int CNT_W = $clog2(COUNT + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;

  logic                 accept;
  logic [ACC_WIDTH-1:0] op_ext;
  logic [ACC_WIDTH:0]   sum_full;
  logic [ACC_WIDTH-1:0] acc_next;
  logic [CNT_W-1:0]     cnt_inc;
  logic                 last_op;

  assign accept   = in_valid && in_ready;
  assign op_ext   = ACC_WIDTH'({in_cout, in_sum});
  assign sum_full = {1'b0, acc_q} + {1'b0, op_ext};
  assign cnt_inc  = cnt_q + CNT_W'(1);
  // cnt is 0 in IDLE, so the same test also covers COUNT==1 on the first operand
  assign last_op  = (cnt_inc == CNT_W'(COUNT));

`ifdef ADDER4_ACCUM_SATURATE_EN
  assign acc_next = (sum_full[ACC_WIDTH] || ovf_q) ? {ACC_WIDTH{1'b1}} : sum_full[ACC_WIDTH-1:0];
`else
  assign acc_next = sum_full[ACC_WIDTH-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // clear wins over everything, including a same-cycle accept or output handshake
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (clear) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            acc_d   = op_ext;
            cnt_d   = cnt_inc;
            ovf_d   = 1'b0;
            state_d = last_op ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_d   = acc_next;
            cnt_d   = cnt_inc;
            ovf_d   = ovf_q | sum_full[ACC_WIDTH];
            state_d = last_op ? DONE : ACCUM;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q != DONE);
    out_valid = (state_q == DONE);
  end

  assign out_acc = acc_q;
  assign out_ovf = ovf_q;

endmodule

// File: tb/tb_adder4_accum.sv
// Self-checking bench for adder4_accum: default, narrow-accumulator (ACC_WIDTH=6) and COUNT=1 instances share one stimulus.
module tb_adder4_accum;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_sum;
  logic       in_cout;
  logic       clear;
  logic       out_ready;

  logic       ready_a, valid_a, ovf_a;
  logic [7:0] acc_a;
  logic       ready_b, valid_b, ovf_b;
  logic [5:0] acc_b;
  logic       ready_c, valid_c, ovf_c;
  logic [7:0] acc_c;

  int checks;
  int errors;

  adder4_accum #(.WIDTH(4), .ACC_WIDTH(8), .COUNT(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ready_a),
    .in_sum(in_sum), .in_cout(in_cout), .clear(clear), .out_valid(valid_a),
    .out_ready(out_ready), .out_acc(acc_a), .out_ovf(ovf_a)
  );

  adder4_accum #(.WIDTH(4), .ACC_WIDTH(6), .COUNT(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ready_b),
    .in_sum(in_sum), .in_cout(in_cout), .clear(clear), .out_valid(valid_b),
    .out_ready(out_ready), .out_acc(acc_b), .out_ovf(ovf_b)
  );

  adder4_accum #(.WIDTH(4), .ACC_WIDTH(8), .COUNT(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ready_c),
    .in_sum(in_sum), .in_cout(in_cout), .clear(clear), .out_valid(valid_c),
    .out_ready(out_ready), .out_acc(acc_c), .out_ovf(ovf_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic       cout;
    logic [3:0] sum;
    logic       clr;
    logic       ordy;
    logic       e_valid;
    logic       e_ready;
    logic [7:0] e_acc;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[17];

  // Drive one cycle of inputs, then land 1 time unit after the rising edge
  task automatic applyStimulus(input logic v, input logic c, input logic [3:0] s,
                               input logic clr, input logic ordy);
    in_valid  = v;
    in_cout   = c;
    in_sum    = s;
    clear     = clr;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic checkA(input string tag, input logic v, input logic r,
                        input int acc, input logic ovf);
    checkOutput({tag, " out_valid"}, int'(valid_a), int'(v));
    checkOutput({tag, " in_ready"},  int'(ready_a), int'(r));
    checkOutput({tag, " out_acc"},   int'(acc_a),   acc);
    checkOutput({tag, " out_ovf"},   int'(ovf_a),   int'(ovf));
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sum    = 4'd0;
    in_cout   = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b0;

    // valid cout sum clr ordy | e_valid e_ready e_acc e_ovf
    vecs[0]  = '{1'b1, 1'b0, 4'd8,  1'b0, 1'b0, 1'b0, 1'b1, 8'd8,   1'b0};
    vecs[1]  = '{1'b1, 1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 8'd24,  1'b0};
    vecs[2]  = '{1'b1, 1'b0, 4'd15, 1'b0, 1'b0, 1'b0, 1'b1, 8'd39,  1'b0};
    vecs[3]  = '{1'b1, 1'b1, 4'd15, 1'b0, 1'b0, 1'b1, 1'b0, 8'd70,  1'b0};
    vecs[4]  = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 8'd70,  1'b0};
    vecs[5]  = '{1'b1, 1'b0, 4'd5,  1'b0, 1'b0, 1'b1, 1'b0, 8'd70,  1'b0};
    vecs[6]  = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 1'b1, 8'd0,   1'b0};
    vecs[7]  = '{1'b1, 1'b0, 4'd5,  1'b0, 1'b1, 1'b0, 1'b1, 8'd5,   1'b0};
    vecs[8]  = '{1'b0, 1'b1, 4'd15, 1'b0, 1'b1, 1'b0, 1'b1, 8'd5,   1'b0};
    vecs[9]  = '{1'b0, 1'b0, 4'd7,  1'b0, 1'b0, 1'b0, 1'b1, 8'd5,   1'b0};
    vecs[10] = '{1'b1, 1'b0, 4'd5,  1'b0, 1'b0, 1'b0, 1'b1, 8'd10,  1'b0};
    vecs[11] = '{1'b1, 1'b1, 4'd15, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0,   1'b0};
    vecs[12] = '{1'b1, 1'b1, 4'd15, 1'b0, 1'b0, 1'b0, 1'b1, 8'd31,  1'b0};
    vecs[13] = '{1'b1, 1'b1, 4'd15, 1'b0, 1'b0, 1'b0, 1'b1, 8'd62,  1'b0};
    vecs[14] = '{1'b1, 1'b1, 4'd15, 1'b0, 1'b0, 1'b0, 1'b1, 8'd93,  1'b0};
    vecs[15] = '{1'b1, 1'b1, 4'd15, 1'b0, 1'b0, 1'b1, 1'b0, 8'd124, 1'b0};
    vecs[16] = '{1'b1, 1'b1, 4'd15, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0,   1'b0};

    #12;
    checkA("reset", 1'b0, 1'b1, 0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].cout, vecs[i].sum, vecs[i].clr, vecs[i].ordy);
      checkA($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_ready, int'(vecs[i].e_acc), vecs[i].e_ovf);
    end

    // Narrow accumulator: four (1,15) operands overflow 6 bits on the third one
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 4'd15, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 4'd15, 1'b0, 1'b0);
    checkOutput("w6 acc2", int'(acc_b), 62);
    checkOutput("w6 ovf2", int'(ovf_b), 0);
    applyStimulus(1'b1, 1'b1, 4'd15, 1'b0, 1'b0);
`ifdef ADDER4_ACCUM_SATURATE_EN
    checkOutput("w6 acc3", int'(acc_b), 63);
`else
    checkOutput("w6 acc3", int'(acc_b), 29);
`endif
    checkOutput("w6 ovf3", int'(ovf_b), 1);
    applyStimulus(1'b1, 1'b1, 4'd15, 1'b0, 1'b0);
`ifdef ADDER4_ACCUM_SATURATE_EN
    checkOutput("w6 acc4", int'(acc_b), 63);
`else
    checkOutput("w6 acc4", int'(acc_b), 60);
`endif
    checkOutput("w6 ovf4", int'(ovf_b), 1);
    checkOutput("w6 valid", int'(valid_b), 1);

    // Backpressure: block of four (0,1), held 5 cycles, then released
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 4'd1, 1'b0, 1'b0);
    checkA("bp done", 1'b1, 1'b0, 4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 4'd9, 1'b0, 1'b0);
      checkA($sformatf("bp hold%0d", i), 1'b1, 1'b0, 4, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    checkA("bp release", 1'b0, 1'b1, 0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 4'd2, 1'b0, 1'b0);
    checkA("bp next", 1'b1, 1'b0, 8, 1'b0);

    // clear mid-block together with in_valid
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'd10, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'd10, 1'b0, 1'b0);
    checkA("clr pre", 1'b0, 1'b1, 20, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'd10, 1'b1, 1'b0);
    checkA("clr post", 1'b0, 1'b1, 0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 4'd1, 1'b0, 1'b0);
    checkA("clr next", 1'b1, 1'b0, 4, 1'b0);

    // Async reset while in DONE, away from any clock edge
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkA("async rst", 1'b0, 1'b1, 0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    applyStimulus(1'b1, 1'b0, 4'd3, 1'b0, 1'b0);
    checkA("after rst", 1'b0, 1'b1, 3, 1'b0);

    // COUNT=1: single operand completes a block
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'd9, 1'b0, 1'b0);
    checkOutput("c1 valid", int'(valid_c), 1);
    checkOutput("c1 acc",   int'(acc_c),   9);
    checkOutput("c1 ready", int'(ready_c), 0);
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    checkOutput("c1 idle valid", int'(valid_c), 0);
    checkOutput("c1 idle ready", int'(ready_c), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
